// File: rtl/clk_en_gen.sv
// Clock-enable and reset sequencer: NUM_CH programmable tick channels with
// derived square waves, a synchronized/stretched reset and a free-running cycle counter.
module clk_en_gen #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int DEF_DIV  = 1,
    parameter int RST_HOLD = 16,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
    input  logic [NUM_CH-1:0] ch_run,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] toggle,
    output logic              sys_rst_n_out,
    output logic [31:0]       cycle_cnt
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    logic [1:0]        rst_sync;
    logic [HOLD_W-1:0] hold_cnt;

    logic [CNT_W-1:0]  div_act    [NUM_CH];
    logic [CNT_W-1:0]  div_shadow [NUM_CH];
    logic [CNT_W-1:0]  phase      [NUM_CH];
    logic [CNT_W-1:0]  cnt        [NUM_CH];
    logic [NUM_CH-1:0] run_q;

    logic [NUM_CH-1:0] wr;
    logic [NUM_CH-1:0] hit;
    logic [CNT_W-1:0]  div_nx    [NUM_CH];
    logic [CNT_W-1:0]  ph_nx     [NUM_CH];
    logic [CNT_W-1:0]  start_cnt [NUM_CH];

    // Two-flop synchronizer followed by a hold counter; the release edge lands
    // on the (2+RST_HOLD)th rising edge after RST_N goes high.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_sync      <= 2'b00;
            hold_cnt      <= '0;
            sys_rst_n_out <= 1'b0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
            if (rst_sync[1] && !sys_rst_n_out) begin
                if (hold_cnt == HOLD_W'(RST_HOLD - 1))
                    sys_rst_n_out <= 1'b1;
                else
                    hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            cycle_cnt <= 32'd0;
        else if (sys_rst_n_out)
            cycle_cnt <= cycle_cnt + 32'd1;
    end

    // A write landing on the same edge as a start or wrap must be visible to it,
    // so the "next" divisor/phase already include this cycle's write.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr[i]        = cfg_we && (int'(cfg_ch) == i);
            hit[i]       = (cnt[i] == div_act[i]);
            div_nx[i]    = wr[i] ? cfg_div : div_shadow[i];
            ph_nx[i]     = wr[i] ? cfg_phase : phase[i];
            start_cnt[i] = (ph_nx[i] < div_nx[i]) ? ph_nx[i] : div_nx[i];
        end
    end

    assign tick = run_q & hit;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_act[i]    <= CNT_W'(DEF_DIV);
                div_shadow[i] <= CNT_W'(DEF_DIV);
                phase[i]      <= '0;
                cnt[i]        <= '0;
            end
            run_q  <= '0;
            toggle <= '0;
        end else if (sys_rst_n_out) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr[i]) begin
                    phase[i]      <= cfg_phase;
                    div_shadow[i] <= cfg_div;
                end
                if (tick[i])
                    toggle[i] <= ~toggle[i];
                if (!run_q[i]) begin
                    if (ch_run[i]) begin
                        run_q[i]   <= 1'b1;
                        div_act[i] <= div_nx[i];
                        cnt[i]     <= start_cnt[i];
                    end else if (wr[i]) begin
                        div_act[i] <= cfg_div;
                    end
                end else if (!ch_run[i]) begin
                    run_q[i] <= 1'b0;
                end else if (hit[i]) begin
                    cnt[i]     <= '0;
                    div_act[i] <= div_nx[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// Bench for clk_en_gen: hand-written reset/corner sequences, a vector table for
// the basic divider, and random traffic checked against a period-position model.
module tb_clk_en_gen;

    localparam int NCH  = 5;
    localparam int CW   = 16;
    localparam int DEFD = 1;
    localparam int HOLD = 4;

    logic           CLK = 1'b0;
    logic           RST_N = 1'b1;
    logic           cfg_we = 1'b0;
    logic [2:0]     cfg_ch = 3'd0;
    logic [CW-1:0]  cfg_div = '0;
    logic [CW-1:0]  cfg_phase = '0;
    logic [NCH-1:0] ch_run = '0;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] toggle;
    logic           sys_rst_n_out;
    logic [31:0]    cycle_cnt;

    clk_en_gen #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(DEFD), .RST_HOLD(HOLD)) dut (
        .CLK(CLK), .RST_N(RST_N), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_phase(cfg_phase), .ch_run(ch_run),
        .tick(tick), .toggle(toggle), .sys_rst_n_out(sys_rst_n_out),
        .cycle_cnt(cycle_cnt)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: each channel tracks its position within the current period.
    int          m_rel;
    logic [31:0] m_cyc;
    int          m_div [NCH];
    int          m_shadow [NCH];
    int          m_phase [NCH];
    int          m_pos [NCH];
    bit          m_run [NCH];
    bit          m_tog [NCH];

    task automatic model_reset();
        m_rel = 0;
        m_cyc = 32'd0;
        for (int i = 0; i < NCH; i++) begin
            m_div[i] = DEFD; m_shadow[i] = DEFD; m_phase[i] = 0;
            m_pos[i] = 0; m_run[i] = 0; m_tog[i] = 0;
        end
    endtask

    function automatic bit m_sys();
        return m_rel >= 2 + HOLD;
    endfunction

    function automatic logic [NCH-1:0] exp_tick();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_run[i] && (m_pos[i] == m_div[i]);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_tog();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_tog[i];
        return v;
    endfunction

    task automatic model_edge();
        logic [NCH-1:0] tk;
        bit wr;
        if (!RST_N) begin
            model_reset();
            return;
        end
        if (m_sys()) begin
            m_cyc = m_cyc + 32'd1;
            tk = exp_tick();
            for (int i = 0; i < NCH; i++) begin
                wr = cfg_we && (int'(cfg_ch) == i);
                if (tk[i]) m_tog[i] = !m_tog[i];
                if (wr) begin
                    m_phase[i] = int'(cfg_phase);
                    m_shadow[i] = int'(cfg_div);
                end
                if (!m_run[i]) begin
                    if (ch_run[i]) begin
                        m_run[i] = 1;
                        m_div[i] = m_shadow[i];
                        m_pos[i] = (m_phase[i] < m_div[i]) ? m_phase[i] : m_div[i];
                    end else if (wr) begin
                        m_div[i] = int'(cfg_div);
                    end
                end else if (!ch_run[i]) begin
                    m_run[i] = 0;
                end else if (m_pos[i] == m_div[i]) begin
                    m_pos[i] = 0;
                    m_div[i] = m_shadow[i];
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                end
            end
        end
        if (m_rel < 1000) m_rel = m_rel + 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_all();
        chk("tick", 32'(tick), 32'(exp_tick()));
        chk("toggle", 32'(toggle), 32'(exp_tog()));
        chk("sys_rst", 32'(sys_rst_n_out), 32'(m_sys()));
        chk("cycle_cnt", cycle_cnt, m_cyc);
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic write_cfg(input int ch, input int dv, input int ph);
        cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_div = CW'(dv); cfg_phase = CW'(ph);
        step();
        cfg_we = 1'b0;
    endtask

    typedef struct {
        logic           we;
        logic [2:0]     ch;
        logic [CW-1:0]  dv;
        logic [CW-1:0]  ph;
        logic [NCH-1:0] run;
        logic           e_tick;
        logic           e_tog;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [0:6] pat;
        bit         tog_hold;

        // Reset values and release timing
        #1 RST_N = 1'b0;
        model_reset();
        repeat (3) step();
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_toggle", 32'(toggle), 32'd0);
        chk("rst_sys", 32'(sys_rst_n_out), 32'd0);
        chk("rst_cyc", cycle_cnt, 32'd0);
        @(negedge CLK); RST_N = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("rel_edge", 32'(sys_rst_n_out), 32'(k == 6));
        end
        step();
        chk("cyc_first", cycle_cnt, 32'd1);

        // Asynchronous drop after release, then a drop mid-hold restarts the sequence
        @(negedge CLK); RST_N = 1'b0;
        #1 model_reset();
        chk("drop_sys", 32'(sys_rst_n_out), 32'd0);
        chk("drop_cyc", cycle_cnt, 32'd0);
        @(negedge CLK); RST_N = 1'b1;
        repeat (3) step();
        RST_N = 1'b0;
        #1 model_reset();
        chk("midhold_sys", 32'(sys_rst_n_out), 32'd0);
        @(negedge CLK); RST_N = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("rerel_edge", 32'(sys_rst_n_out), 32'(k == 6));
        end

        // Basic divide on ch0: div=3, phase=0
        tbl[0]  = '{1'b1, 3'd0, 16'd3, 16'd0, 5'b00000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 3'd0, 16'd0, 16'd0, 5'b00001, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 3'd0, 16'd0, 16'd0, 5'b00001, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 3'd0, 16'd0, 16'd0, 5'b00001, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 3'd0, 16'd0, 16'd0, 5'b00001, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 3'd0, 16'd0, 16'd0, 5'b00001, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 3'd0, 16'd0, 16'd0, 5'b00001, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 3'd0, 16'd0, 16'd0, 5'b00001, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 3'd0, 16'd0, 16'd0, 5'b00001, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 3'd0, 16'd0, 16'd0, 5'b00001, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 16'd0, 16'd0, 5'b00001, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 3'd0, 16'd0, 16'd0, 5'b00001, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 3'd0, 16'd0, 16'd0, 5'b00001, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 3'd0, 16'd0, 16'd0, 5'b00001, 1'b0, 1'b1};
        for (int v = 0; v < 14; v++) begin
            cfg_we = tbl[v].we; cfg_ch = tbl[v].ch; cfg_div = tbl[v].dv;
            cfg_phase = tbl[v].ph; ch_run = tbl[v].run;
            step();
            chk("tbl_tick0", 32'(tick[0]), 32'(tbl[v].e_tick));
            chk("tbl_tog0", 32'(toggle[0]), 32'(tbl[v].e_tog));
        end
        cfg_we = 1'b0;

        // Phase offset and clipping on ch1
        write_cfg(1, 5, 4);
        ch_run[1] = 1'b1; step();
        chk("phase_start", 32'(tick[1]), 32'd0);
        step();
        chk("phase_first", 32'(tick[1]), 32'd1);
        ch_run[1] = 1'b0; step();
        write_cfg(1, 5, 9);
        ch_run[1] = 1'b1; step();
        chk("phase_clip", 32'(tick[1]), 32'd1);

        // Live reprogram: div 7 -> 1 mid-period, then an out-of-range write
        ch_run[1] = 1'b0; step();
        write_cfg(1, 7, 0);
        ch_run[1] = 1'b1; step();
        repeat (3) step();
        write_cfg(1, 1, 0);
        pat = 7'b0010101;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("reprog_tick1", 32'(tick[1]), 32'(pat[k]));
        end
        write_cfg(7, 2, 3);
        chk("oor_tick1", 32'(tick[1]), 32'd0);
        step();
        chk("oor_tick1b", 32'(tick[1]), 32'd1);

        // Stop at cnt=2, restart, then div=0
        write_cfg(2, 5, 1);
        ch_run[2] = 1'b1; step();
        step();
        ch_run[2] = 1'b0; step();
        tog_hold = m_tog[2];
        repeat (3) begin
            step();
            chk("stop_tick2", 32'(tick[2]), 32'd0);
            chk("stop_tog2", 32'(toggle[2]), 32'(tog_hold));
        end
        ch_run[2] = 1'b1; step();
        repeat (6) step();
        ch_run[2] = 1'b0; step();
        write_cfg(2, 0, 0);
        ch_run[2] = 1'b1;
        repeat (5) begin
            step();
            chk("div0_tick2", 32'(tick[2]), 32'd1);
        end

        // Write and start on the same edge for ch3
        cfg_we = 1'b1; cfg_ch = 3'd3; cfg_div = 16'd3; cfg_phase = 16'd1; ch_run[3] = 1'b1;
        step();
        cfg_we = 1'b0;
        chk("simul_start", 32'(tick[3]), 32'd0);
        step();
        chk("simul_first0", 32'(tick[3]), 32'd0);
        step();
        chk("simul_first1", 32'(tick[3]), 32'd1);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            cfg_we = ($urandom_range(0, 3) == 0);
            cfg_ch = 3'($urandom_range(0, 7));
            cfg_div = CW'($urandom_range(0, 9));
            cfg_phase = CW'($urandom_range(0, 12));
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 7) == 0) ch_run[i] = !ch_run[i];
            step();
        end
        cfg_we = 1'b0;

        // cycle_cnt wrap
        @(negedge CLK);
        force dut.cycle_cnt = 32'hFFFF_FFFE;
        #1 release dut.cycle_cnt;
        m_cyc = 32'hFFFF_FFFE;
        step();
        chk("cyc_max", cycle_cnt, 32'hFFFF_FFFF);
        step();
        chk("cyc_wrap", cycle_cnt, 32'd0);

        // Asynchronous reset while channels are running
        ch_run = 5'b11111;
        repeat (4) step();
        RST_N = 1'b0;
        #1 model_reset();
        chk("arst_tick", 32'(tick), 32'd0);
        chk("arst_toggle", 32'(toggle), 32'd0);
        chk("arst_sys", 32'(sys_rst_n_out), 32'd0);
        chk("arst_cyc", cycle_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
